// File: rtl/conv_mac_layer_if.sv
// Stream-in, stream-out and coefficient-load bus of the convolution MAC layer.
// master = upstream/downstream/loader side, slave = the layer itself.
interface conv_mac_layer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_NODES   = 16,
    parameter int KERNAL_SIZE = 3,
    parameter int DEPTH       = 8
);
    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int IDX_W  = $clog2(KERNAL_SIZE * KERNAL_SIZE + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [DEPTH*DATA_WIDTH-1:0]     data_in;
    logic                            coef_we;
    logic [NODE_W-1:0]               coef_node;
    logic [IDX_W-1:0]                coef_idx;
    logic [DEPTH*DATA_WIDTH-1:0]     coef_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NODES*DATA_WIDTH-1:0] data_out;

    modport master (
        output in_valid, data_in, coef_we, coef_node, coef_idx, coef_data, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, coef_we, coef_node, coef_idx, coef_data, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/conv_mac_layer.sv
// Streaming convolution layer: one kernel tap of DEPTH channels per beat, NUM_NODES
// parallel MAC accumulators, fixed-point round-down/saturate/ReLU on window completion.
module conv_mac_layer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_NODES   = 16,
    parameter int KERNAL_SIZE = 3,
    parameter int DEPTH       = 8,
    parameter int ACC_WIDTH   = 40,
    parameter int RELU_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              layer_active,
    output logic              busy,
    conv_mac_layer_if.slave   bus
);
    localparam int TAPS   = KERNAL_SIZE * KERNAL_SIZE;
    localparam int TAP_W  = $clog2(TAPS + 1);
    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int DW     = DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {ACCUM, OUTPUT} state_t;

    state_t                         state_reg, state_next;
    logic [TAP_W-1:0]               tap_reg, tap_next;
    logic [TAP_W-1:0]               tap_idx;
    logic signed [DW-1:0]           w_reg    [NUM_NODES][TAPS][DEPTH];
    logic signed [DW-1:0]           bias_reg [NUM_NODES];
    logic signed [ACC_WIDTH-1:0]    acc_reg  [NUM_NODES];
    logic signed [ACC_WIDTH-1:0]    acc_sum  [NUM_NODES];
    logic [NUM_NODES*DW-1:0]        result_flat;
    logic [NUM_NODES*DW-1:0]        data_out_reg;
    logic                           beat_fire, out_fire, last_beat, coef_ok;

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DW-1:0] v);
        return {{(ACC_WIDTH-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [2*DW-1:0] mul(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] ax, bx;
        ax = {{DW{a[DW-1]}}, a};
        bx = {{DW{b[DW-1]}}, b};
        return ax * bx;
    endfunction

    assign bus.in_ready  = reset && (state_reg == ACCUM) && layer_active;
    assign bus.out_valid = (state_reg == OUTPUT);
    assign bus.data_out  = data_out_reg;
    assign busy          = (tap_reg != '0) || (state_reg == OUTPUT);

    assign beat_fire = bus.in_valid && bus.in_ready;
    assign out_fire  = (state_reg == OUTPUT) && bus.out_ready;
    assign last_beat = beat_fire && (tap_reg == TAP_W'(TAPS - 1));
    assign coef_ok   = bus.coef_we && !layer_active && (state_reg == ACCUM) && (tap_reg == '0)
                       && (bus.coef_idx <= TAP_W'(TAPS))
                       && ({1'b0, bus.coef_node} < (NODE_W+1)'(NUM_NODES));
    // In OUTPUT the counter sits at TAPS; keep the weight read in range.
    assign tap_idx   = (tap_reg < TAP_W'(TAPS)) ? tap_reg : '0;

    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        case (state_reg)
            ACCUM: begin
                if (beat_fire) begin
                    tap_next = tap_reg + 1'b1;
                    if (tap_reg == TAP_W'(TAPS - 1)) begin
                        state_next = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    tap_next   = '0;
                end
            end
            default: begin
                state_next = ACCUM;
                tap_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NODES; gi++) begin : g_node
            logic signed [ACC_WIDTH-1:0] sum;
            logic signed [ACC_WIDTH-1:0] shifted;
            logic signed [2*DW-1:0]      prod;
            logic [DW-1:0]               res;

            always_comb begin
                sum  = acc_reg[gi];
                prod = '0;
                for (int c = 0; c < DEPTH; c++) begin
                    prod = mul(w_reg[gi][tap_idx][c], bus.data_in[c*DW +: DW]);
                    sum  = sum + {{(ACC_WIDTH-2*DW){prod[2*DW-1]}}, prod};
                end
                shifted = sum >>> FRAC_BITS;
                if (shifted > SAT_MAX) begin
                    res = {1'b0, {(DW-1){1'b1}}};
                end else if (shifted < SAT_MIN) begin
                    res = {1'b1, {(DW-1){1'b0}}};
                end else begin
                    res = shifted[DW-1:0];
                end
                if ((RELU_EN != 0) && res[DW-1]) begin
                    res = '0;
                end
            end

            assign acc_sum[gi]               = sum;
            assign result_flat[gi*DW +: DW] = res;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ACCUM;
            tap_reg      <= '0;
            data_out_reg <= '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                acc_reg[n]  <= '0;
                bias_reg[n] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    for (int c = 0; c < DEPTH; c++) begin
                        w_reg[n][t][c] <= '0;
                    end
                end
            end
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            if (last_beat) begin
                data_out_reg <= result_flat;
            end
            for (int n = 0; n < NUM_NODES; n++) begin
                if (out_fire) begin
                    acc_reg[n] <= sext(bias_reg[n]) <<< FRAC_BITS;
                end else if (beat_fire) begin
                    acc_reg[n] <= acc_sum[n];
                end
            end
            // A bias landing between windows also re-seeds that node's accumulator.
            if (coef_ok) begin
                if (bus.coef_idx == TAP_W'(TAPS)) begin
                    bias_reg[bus.coef_node] <= bus.coef_data[DW-1:0];
                    acc_reg[bus.coef_node]  <= sext(bus.coef_data[DW-1:0]) <<< FRAC_BITS;
                end else begin
                    for (int c = 0; c < DEPTH; c++) begin
                        w_reg[bus.coef_node][bus.coef_idx][c] <= bus.coef_data[c*DW +: DW];
                    end
                end
            end
        end
    end
endmodule
